sync_fifo: RTL and testbench
============================

# sync_fifo

Synchronous single-clock FIFO that serves as the design under test driven by the test/env bench through the shared `intf` interface. It buffers `DATA_WIDTH`-bit words between a write port and a read port. It reports occupancy, full/empty and programmable almost-full/almost-empty levels. Rejected accesses are reported as single-cycle error pulses.

## Interface
- `DATA_WIDTH`, 8: width of each stored word.
- `DEPTH`, 16: number of entries; must be a power of 2 and ≥ 2.
- `AF_LEVEL`, 12: `almost_full` asserts when `count >= AF_LEVEL`; range 1..DEPTH.
- `AE_LEVEL`, 4: `almost_empty` asserts when `count <= AE_LEVEL`; range 0..DEPTH-1.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write request.
- `wr_data`  in  DATA_WIDTH  write word, sampled when a write is accepted.
- `rd_en`  in  1  read request.
- `rd_data`  out  DATA_WIDTH  read word, registered.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `almost_full`  out  1  `count >= AF_LEVEL`.
- `almost_empty`  out  1  `count <= AE_LEVEL`.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  one-cycle pulse when a write is rejected.
- `underflow`  out  1  one-cycle pulse when a read is rejected.

## Operation
- Storage is a DEPTH×DATA_WIDTH register array with write pointer `wp` and read pointer `rp`, each $clog2(DEPTH) bits.
- Pointers wrap modulo DEPTH with natural binary rollover; there is no special case at DEPTH-1 → 0.
- Read acceptance: `rd_ok = rd_en & ~empty`.
- Write acceptance: `wr_ok = wr_en & (~full | rd_ok)`.
  - At full, a simultaneous accepted read frees a slot, so the write is also accepted.
- Empty with `wr_en` and `rd_en` both high:
  - The read is rejected and `underflow` pulses.
  - The write is accepted.
  - There is no fall-through: the new word is readable no earlier than the next cycle.
- On `wr_ok`: `mem[wp] <= wr_data` and `wp <= wp+1`.
- On `rd_ok`: `rd_data <= mem[rp]` and `rp <= rp+1`.
- When no read is accepted, `rd_data` holds its previous value.
- Count update: `count <= count + wr_ok - rd_ok`.
  - Both accepted: count unchanged.
  - Count never exceeds DEPTH and never goes below 0.
- `full`, `empty`, `almost_full`, `almost_empty` are registered. Each is computed from the next-state count, so it is exact in the same cycle that `count` changes.
- `overflow <= wr_en & ~wr_ok`.
- `underflow <= rd_en & ~rd_ok`.
- Rejected operations change no storage, pointer or count state.
- Reset values: `wp`=0, `rp`=0, `count`=0, `rd_data`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0, `overflow`=0, `underflow`=0.
- Memory contents are not reset.
- Reset asserted mid-operation discards all stored words on that edge.
  - Requests sampled on a reset edge are ignored.
  - Requests sampled on a reset edge produce no error pulse.

## Timing
- Write latency: a word written at edge N is readable by a `rd_en` sampled at edge N+1 or later.
- Read latency: `rd_data` is valid immediately after the edge that accepted the read, i.e. one cycle after `rd_en` is presented.
- Status flags and `count` reflect all accesses accepted at edge N right after edge N.
- `overflow` and `underflow` are high for exactly the one cycle following the rejected request.
- Sustained simultaneous read+write at any occupancy from 1 to DEPTH gives throughput of 1 word/cycle, with `count` constant.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset with outputs checked:
  - Assert `rst` for 2 cycles → `empty`=1, `almost_empty`=1, `count`=0, `rd_data`=0, `full`=0, `overflow`=0, `underflow`=0.
- Fill, then overflow:
  - Write 0x01..0x10 (DEPTH=16) → `count` goes 1..16; `almost_full` rises when count reaches 12; `full`=1 after the 16th write.
  - A 17th write → `overflow` pulses one cycle and `count` stays 16.
- Drain in order, then underflow:
  - Read 16 times → `rd_data` = 0x01..0x10 in order, each valid one cycle after its `rd_en`; `almost_empty` rises when count reaches 4; `empty`=1 at the end.
  - One more read → `underflow` pulse, and `rd_data` holds 0x10.
- Simultaneous access at the boundaries:
  - At full, assert `wr_en`+`rd_en` with data 0xAA → both accepted, `count`=16, no `overflow`.
  - At empty, assert `wr_en`+`rd_en` with data 0x55 → `underflow` pulses, `count`=1; the next read returns 0x55.
- Pointer wrap-around:
  - Run 40 cycles of interleaved write/read at occupancy 3 with an incrementing data pattern → output sequence identical to input with no gaps, covering ≥2 full pointer wraps.
- Reset mid-operation:
  - With `count`=7, assert `rst` while `wr_en`=1 → next cycle `count`=0, `empty`=1, `overflow`=0.
  - A subsequent write of 0x3C followed by a read returns 0x3C.

Source files
------------

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered read data, occupancy count,
//               full/empty and programmable almost-full/almost-empty flags,
//               and one-cycle overflow/underflow pulses for rejected requests.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,  // power of 2, >= 2
  parameter int AF_LEVEL   = 12,  // 1..DEPTH
  parameter int AE_LEVEL   = 4    // 0..DEPTH-1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF_LEVEL = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_AE_LEVEL = CW'(AE_LEVEL);

  // Storage array; contents are deliberately left unreset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]         wp_q, wp_d;
  logic [AW-1:0]         rp_q, rp_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  rd_ok;
  logic                  wr_ok;

  // Acceptance decisions and next-state values; a read at full frees the
  // slot the simultaneous write needs, but a write at empty never feeds the
  // same-cycle read (no fall-through).
  always_comb begin
    rd_ok          = rd_en & ~empty_q;
    wr_ok          = wr_en & (~full_q | rd_ok);

    wp_d           = wr_ok ? wp_q + AW'(1) : wp_q;
    rp_d           = rd_ok ? rp_q + AW'(1) : rp_q;
    count_d        = count_q + CW'(wr_ok) - CW'(rd_ok);
    rd_data_d      = rd_ok ? mem_q[rp_q] : rd_data_q;

    // Flags come from the next count so they track count on the same edge.
    full_d         = (count_d == C_DEPTH);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= C_AF_LEVEL);
    almost_empty_d = (count_d <= C_AE_LEVEL);

    overflow_d     = wr_en & ~wr_ok;
    underflow_d    = rd_en & ~rd_ok;
  end

  // Control and status registers; reset discards all requests on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q           <= '0;
      rp_q           <= '0;
      count_q        <= '0;
      rd_data_q      <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wp_q           <= wp_d;
      rp_q           <= rp_d;
      count_q        <= count_d;
      rd_data_q      <= rd_data_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Memory write port; a write presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem_q[wp_q] <= wr_data;
    end
  end

  assign rd_data      = rd_data_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Self-checking bench for sync_fifo. A queue-based reference
//               model predicts status each cycle and pushes expected read
//               words into a scoreboard; a monitor pops them on every read
//               handshake it observes at the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;
  localparam int AF_LEVEL   = 12;
  localparam int AE_LEVEL   = 4;

  logic                   clk;
  logic                   rst;
  logic                   wr_en;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic                   rd_en;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic                   full;
  logic                   empty;
  logic                   almost_full;
  logic                   almost_empty;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   underflow;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (AF_LEVEL),
    .AE_LEVEL   (AE_LEVEL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: contents of the FIFO as a plain queue.
  logic [DATA_WIDTH-1:0] model_q [$];
  // Scoreboard: words the DUT is expected to present on rd_data, in order.
  logic [DATA_WIDTH-1:0] sb_q [$];
  bit exp_ovf = 1'b0;
  bit exp_udf = 1'b0;
  logic [DATA_WIDTH-1:0] exp_hold = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive requests, advance the model on the edge, then
  // compare every status output against the model.
  task automatic cycle(input bit w, input bit r, input logic [DATA_WIDTH-1:0] d, input bit rs);
    bit rd_acc;
    bit wr_acc;
    wr_en   = w;
    rd_en   = r;
    wr_data = d;
    rst     = rs;
    @(posedge clk);
    if (rs) begin
      model_q.delete();
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end else begin
      rd_acc = r && (model_q.size() > 0);
      wr_acc = w && ((model_q.size() < DEPTH) || rd_acc);
      if (rd_acc) sb_q.push_back(model_q.pop_front());
      if (wr_acc) model_q.push_back(d);
      exp_ovf = w && !wr_acc;
      exp_udf = r && !rd_acc;
    end
    #1;
    chk("count",        int'(count),        model_q.size());
    chk("full",         int'(full),         int'(model_q.size() == DEPTH));
    chk("empty",        int'(empty),        int'(model_q.size() == 0));
    chk("almost_full",  int'(almost_full),  int'(model_q.size() >= AF_LEVEL));
    chk("almost_empty", int'(almost_empty), int'(model_q.size() <= AE_LEVEL));
    chk("overflow",     int'(overflow),     int'(exp_ovf));
    chk("underflow",    int'(underflow),    int'(exp_udf));
  endtask

  // Monitor: a read handshake is rd_en while the DUT reports non-empty;
  // the word it produced must be the next scoreboard entry, otherwise
  // rd_data must hold its last value.
  bit mon_hs;
  bit mon_rs;
  always @(posedge clk) begin
    mon_hs = rd_en && !empty && !rst;
    mon_rs = rst;
    #1;
    if (mon_rs) begin
      exp_hold = '0;
      chk("rd_data_reset", int'(rd_data), 0);
    end else if (mon_hs) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_read: got %0h expected no read at %0t", rd_data, $time);
      end else begin
        exp_hold = sb_q.pop_front();
        chk("rd_data", int'(rd_data), int'(exp_hold));
      end
    end else begin
      chk("rd_data_hold", int'(rd_data), int'(exp_hold));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_WIDTH-1:0] d;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    rst     = 1'b1;

    // Reset for two cycles.
    cycle(0, 0, 8'h00, 1);
    cycle(0, 0, 8'h00, 1);

    // Fill with 0x01..0x10, then one rejected write.
    for (int i = 1; i <= DEPTH; i++) cycle(1, 0, DATA_WIDTH'(i), 0);
    cycle(1, 0, 8'hEE, 0);
    cycle(0, 0, 8'h00, 0);

    // Drain in order, then one rejected read (rd_data must hold 0x10).
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'h00, 0);
    cycle(0, 1, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);

    // Simultaneous access at full.
    for (int i = 0; i < DEPTH; i++) cycle(1, 0, DATA_WIDTH'(8'h80 + i), 0);
    cycle(1, 1, 8'hAA, 0);
    for (int i = 0; i < DEPTH; i++) cycle(0, 1, 8'h00, 0);

    // Simultaneous access at empty, then read the word back.
    cycle(1, 1, 8'h55, 0);
    cycle(0, 1, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);

    // Pointer wrap at occupancy 3 with an incrementing pattern.
    d = 8'h00;
    for (int i = 0; i < 3; i++) begin cycle(1, 0, d, 0); d = d + 8'h01; end
    for (int i = 0; i < 40; i++) begin cycle(1, 1, d, 0); d = d + 8'h01; end
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'h00, 0);

    // Reset mid-operation at count 7 with a write pending.
    for (int i = 0; i < 7; i++) cycle(1, 0, DATA_WIDTH'(8'h60 + i), 0);
    cycle(1, 0, 8'hFF, 1);
    cycle(1, 0, 8'h3C, 0);
    cycle(0, 1, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);

    // Randomized traffic with phases biased toward fill, drain and balance.
    for (int ph = 0; ph < 6; ph++) begin
      int wp_pct;
      int rp_pct;
      wp_pct = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      rp_pct = 100 - wp_pct;
      for (int i = 0; i < 100; i++) begin
        cycle(($urandom_range(99) < wp_pct), ($urandom_range(99) < rp_pct),
              DATA_WIDTH'($urandom), ($urandom_range(199) == 0));
      end
    end

    // Drain what is left and confirm the scoreboard emptied.
    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 1, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
